// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: bus-side init/INTA/EOI sequencer for an 8259-style PIC
module pic_host_sequencer #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       eoi_req,
  input  logic [7:0] eoi_cmd,
  output logic       eoi_ack,
  input  logic       pic_int,
  output logic       pic_cs_n,
  output logic       pic_wr_n,
  output logic       pic_rd_n,
  output logic       pic_a0,
  output logic       pic_inta_n,
  output logic [7:0] pic_data_out,
  output logic       pic_data_oe,
  input  logic [7:0] pic_data_in,
  output logic       init_done,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       busy
);
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("STROBE_CYCLES must be in 1..15");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("GAP_CYCLES must be in 1..15");
  end
  localparam logic [3:0] S_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] G_LOAD = 4'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INIT, READY, EOI_WR, ACK1, ACK_GAP, ACK2, VEC} state_t;
  typedef enum logic [1:0] {W_SETUP, W_STROBE, W_HOLD} phase_t;
  state_t      state;
  phase_t      phase;
  logic [3:0]  cnt;
  logic [2:0]  step;
  logic [1:0]  cfg;
  logic [7:0]  w2, w3, w4, wo;
  logic [1:0]  int_sync;
  logic        int_s;
  logic [2:0]  nxt_step;
  logic [7:0]  nxt_data;
  assign pic_rd_n = 1'b1;
  assign int_s    = int_sync[1];
  // two-flop synchronizer for the asynchronous INT line
  always_ff @(posedge clk or posedge reset)
    if (reset) int_sync <= '0;
    else int_sync <= {int_sync[0], pic_int};
  // next init word: steps are ICW1..ICW4, OCW1; ICW3 needs SNGL=0, ICW4 needs IC4=1
  always_comb begin
    nxt_step = step == 3'd0 ? 3'd1 :
               (step == 3'd1 && !cfg[1]) ? 3'd2 :
               (step <= 3'd2 && cfg[0]) ? 3'd3 : 3'd4;
    nxt_data = nxt_step == 3'd1 ? w2 : nxt_step == 3'd2 ? w3 : nxt_step == 3'd3 ? w4 : wo;
  end
  // main sequencer with registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= W_SETUP;
      cnt          <= '0;
      step         <= '0;
      cfg          <= '0;
      w2           <= '0;
      w3           <= '0;
      w4           <= '0;
      wo           <= '0;
      pic_cs_n     <= 1'b1;
      pic_wr_n     <= 1'b1;
      pic_inta_n   <= 1'b1;
      pic_a0       <= 1'b0;
      pic_data_out <= '0;
      pic_data_oe  <= 1'b0;
      init_done    <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
      eoi_ack      <= 1'b0;
      busy         <= 1'b0;
    end else if (start_init) begin
      state        <= INIT;
      phase        <= W_SETUP;
      step         <= 3'd0;
      cfg          <= icw1[1:0];
      w2           <= icw2;
      w3           <= icw3;
      w4           <= icw4;
      wo           <= ocw1;
      pic_cs_n     <= 1'b0;
      pic_wr_n     <= 1'b1;
      pic_inta_n   <= 1'b1;
      pic_a0       <= 1'b0;
      pic_data_out <= icw1;
      pic_data_oe  <= 1'b1;
      init_done    <= 1'b0;
      vector_valid <= 1'b0;
      eoi_ack      <= 1'b0;
      busy         <= 1'b1;
    end else begin
      vector_valid <= 1'b0;
      eoi_ack      <= 1'b0;
      case (state)
        IDLE: ;
        READY:
          if (eoi_req && !eoi_ack) begin
            state        <= EOI_WR;
            phase        <= W_SETUP;
            pic_cs_n     <= 1'b0;
            pic_a0       <= 1'b0;
            pic_data_out <= eoi_cmd;
            pic_data_oe  <= 1'b1;
            busy         <= 1'b1;
          end else if (int_s) begin
            state      <= ACK1;
            pic_inta_n <= 1'b0;
            cnt        <= S_LOAD;
            busy       <= 1'b1;
          end
        INIT, EOI_WR:
          case (phase)
            W_SETUP: begin
              phase    <= W_STROBE;
              pic_wr_n <= 1'b0;
              cnt      <= S_LOAD;
            end
            W_STROBE:
              if (cnt == 4'd0) begin
                phase    <= W_HOLD;
                pic_wr_n <= 1'b1;
              end else cnt <= cnt - 4'd1;
            default:
              if (state == INIT && step != 3'd4) begin
                phase        <= W_SETUP;
                step         <= nxt_step;
                pic_a0       <= 1'b1;
                pic_data_out <= nxt_data;
              end else begin
                state       <= READY;
                pic_cs_n    <= 1'b1;
                pic_data_oe <= 1'b0;
                busy        <= 1'b0;
                init_done   <= init_done | (state == INIT);
                eoi_ack     <= state == EOI_WR;
              end
          endcase
        ACK1:
          if (cnt == 4'd0) begin
            state      <= ACK_GAP;
            pic_inta_n <= 1'b1;
            cnt        <= G_LOAD;
          end else cnt <= cnt - 4'd1;
        ACK_GAP:
          if (cnt == 4'd0) begin
            state      <= ACK2;
            pic_inta_n <= 1'b0;
            cnt        <= S_LOAD;
          end else cnt <= cnt - 4'd1;
        ACK2:
          if (cnt == 4'd0) begin
            state        <= VEC;
            pic_inta_n   <= 1'b1;
            vector       <= pic_data_in;
            vector_valid <= 1'b1;
          end else cnt <= cnt - 4'd1;
        VEC: begin
          state <= READY;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb_pic_host_sequencer: transaction-level model and per-cycle checks for pic_host_sequencer
module tb_pic_host_sequencer;
  localparam int S = 2;
  localparam int G = 1;
  logic clk = 1'b0;
  logic reset, start_init, eoi_req, pic_int;
  logic [7:0] icw1, icw2, icw3, icw4, ocw1, eoi_cmd, pic_data_in;
  logic eoi_ack, pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_inta_n, pic_data_oe;
  logic init_done, vector_valid, busy;
  logic [7:0] pic_data_out, vector;
  pic_host_sequencer #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .start_init(start_init),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
    .eoi_req(eoi_req), .eoi_cmd(eoi_cmd), .eoi_ack(eoi_ack), .pic_int(pic_int),
    .pic_cs_n(pic_cs_n), .pic_wr_n(pic_wr_n), .pic_rd_n(pic_rd_n), .pic_a0(pic_a0),
    .pic_inta_n(pic_inta_n), .pic_data_out(pic_data_out), .pic_data_oe(pic_data_oe),
    .pic_data_in(pic_data_in), .init_done(init_done), .vector(vector),
    .vector_valid(vector_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic cs_n, wr_n, inta_n, oe, a0;
    logic [7:0] data;
    logic busy, done, vv, ack;
    logic [7:0] vec;
  } rec_t;
  rec_t exp_q[$];
  rec_t cmp_e;
  logic m_done;
  logic [7:0] m_vec;
  int total = 0;
  int passed = 0;
  logic [8:0] wlog[$];
  logic [8:0] want[$];
  logic prev_wr = 1'b1;
  int inta_lows = 0;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic rec_t mk(input logic cs_n, input logic wr_n, input logic inta_n,
                              input logic oe, input logic a0, input logic [7:0] d, input logic b);
    rec_t r;
    r.cs_n = cs_n; r.wr_n = wr_n; r.inta_n = inta_n; r.oe = oe; r.a0 = a0; r.data = d;
    r.busy = b; r.done = m_done; r.vv = 1'b0; r.ack = 1'b0; r.vec = m_vec;
    return r;
  endfunction
  task automatic quiet(input int n);
    repeat (n) exp_q.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0));
  endtask
  task automatic wr(input logic a0, input logic [7:0] d);
    exp_q.push_back(mk(0, 1, 1, 1, a0, d, 1));
    repeat (S) exp_q.push_back(mk(0, 0, 1, 1, a0, d, 1));
    exp_q.push_back(mk(0, 1, 1, 1, a0, d, 1));
  endtask
  task automatic init_seq(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3,
                          input logic [7:0] i4, input logic [7:0] o);
    m_done = 1'b0;
    wr(0, i1);
    wr(1, i2);
    if (!i1[1]) wr(1, i3);
    if (i1[0]) wr(1, i4);
    wr(1, o);
    m_done = 1'b1;
    quiet(1);
  endtask
  task automatic eoi(input logic [7:0] d);
    rec_t r;
    wr(0, d);
    r = mk(1, 1, 1, 0, 0, 8'h00, 0);
    r.ack = 1'b1;
    exp_q.push_back(r);
  endtask
  task automatic inta(input logic [7:0] v);
    rec_t r;
    repeat (S) exp_q.push_back(mk(1, 1, 0, 0, 0, 8'h00, 1));
    repeat (G) exp_q.push_back(mk(1, 1, 1, 0, 0, 8'h00, 1));
    repeat (S) exp_q.push_back(mk(1, 1, 0, 0, 0, 8'h00, 1));
    m_vec = v;
    r = mk(1, 1, 1, 0, 0, 8'h00, 1);
    r.vv = 1'b1;
    exp_q.push_back(r);
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask
  task automatic chk_log(input int base);
    chk("wlog_len", 16'(wlog.size() - base), 16'(want.size()));
    for (int i = 0; i < want.size(); i++)
      chk("wlog_word", 16'((base + i < wlog.size()) ? wlog[base + i] : 9'h1FF), 16'(want[i]));
  endtask
  always @(negedge clk) begin
    if (!prev_wr && pic_wr_n) wlog.push_back({pic_a0, pic_data_out});
    if (!pic_inta_n) inta_lows++;
    prev_wr = pic_wr_n;
  end
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      chk("cs_n", 16'(pic_cs_n), 16'(cmp_e.cs_n));
      chk("wr_n", 16'(pic_wr_n), 16'(cmp_e.wr_n));
      chk("rd_n", 16'(pic_rd_n), 16'd1);
      chk("inta_n", 16'(pic_inta_n), 16'(cmp_e.inta_n));
      chk("oe", 16'(pic_data_oe), 16'(cmp_e.oe));
      if (cmp_e.oe) begin
        chk("a0", 16'(pic_a0), 16'(cmp_e.a0));
        chk("data_out", 16'(pic_data_out), 16'(cmp_e.data));
      end
      chk("busy", 16'(busy), 16'(cmp_e.busy));
      chk("init_done", 16'(init_done), 16'(cmp_e.done));
      chk("vector_valid", 16'(vector_valid), 16'(cmp_e.vv));
      chk("eoi_ack", 16'(eoi_ack), 16'(cmp_e.ack));
      chk("vector", 16'(vector), 16'(cmp_e.vec));
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, base, lows;
    reset = 1; start_init = 0; eoi_req = 0; pic_int = 0; eoi_cmd = 0; pic_data_in = 0;
    icw1 = 0; icw2 = 0; icw3 = 0; icw4 = 0; ocw1 = 0;
    m_done = 0; m_vec = 0;
    step(2);
    chk("rst_cs_n", 16'(pic_cs_n), 16'd1);
    chk("rst_wr_n", 16'(pic_wr_n), 16'd1);
    chk("rst_inta_n", 16'(pic_inta_n), 16'd1);
    chk("rst_oe", 16'(pic_data_oe), 16'd0);
    chk("rst_data", 16'(pic_data_out), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_vector", 16'(vector), 16'd0);
    reset = 0;
    step(1);
    quiet(2);
    drain();
    // single PIC with ICW4: ICW3 skipped
    base = wlog.size();
    icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'hAA; icw4 = 8'h01; ocw1 = 8'hF0; start_init = 1;
    quiet(1);
    init_seq(8'h13, 8'h20, 8'hAA, 8'h01, 8'hF0);
    n = 0;
    do begin
      step(1);
      n++;
      if (n == 1) start_init = 0;
    end while (!init_done && n < 100);
    chk("init_latency", 16'(n - 1), 16'd16);
    drain();
    want = '{9'h013, 9'h120, 9'h101, 9'h1F0};
    chk_log(base);
    // cascade without ICW4; inputs change after the start pulse
    base = wlog.size();
    icw1 = 8'h10; icw2 = 8'h28; icw3 = 8'h04; icw4 = 8'h77; ocw1 = 8'hFB; start_init = 1;
    quiet(1);
    init_seq(8'h10, 8'h28, 8'h04, 8'h77, 8'hFB);
    step(1);
    start_init = 0; icw1 = 8'hFF; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; ocw1 = 8'h00;
    drain();
    want = '{9'h010, 9'h128, 9'h104, 9'h1FB};
    chk_log(base);
    // INTA cycle, INT dropped during ACK1
    lows = inta_lows;
    pic_data_in = 8'h23; pic_int = 1;
    quiet(3);
    inta(8'h23);
    quiet(3);
    step(3);
    pic_int = 0;
    drain();
    chk("vector_t3", 16'(vector), 16'h23);
    chk("inta_low_cycles", 16'(inta_lows - lows), 16'd4);
    // EOI and INT together: EOI first
    base = wlog.size();
    pic_data_in = 8'h45; pic_int = 1;
    quiet(3);
    eoi(8'h20);
    inta(8'h45);
    quiet(2);
    step(2);
    eoi_req = 1; eoi_cmd = 8'h20;
    step(5);
    eoi_req = 0;
    step(1);
    pic_int = 0;
    drain();
    want = '{9'h020};
    chk_log(base);
    chk("vector_t4", 16'(vector), 16'h45);
    // reset during ICW2 strobe
    icw1 = 8'h13; icw2 = 8'h20; icw4 = 8'h01; ocw1 = 8'hF0; start_init = 1;
    quiet(1);
    m_done = 0;
    wr(0, 8'h13);
    exp_q.push_back(mk(0, 1, 1, 1, 1, 8'h20, 1));
    exp_q.push_back(mk(0, 0, 1, 1, 1, 8'h20, 1));
    step(1);
    start_init = 0;
    step(5);
    #5;
    reset = 1;
    #1;
    m_done = 0; m_vec = 0;
    chk("abort_wr_n", 16'(pic_wr_n), 16'd1);
    chk("abort_cs_n", 16'(pic_cs_n), 16'd1);
    chk("abort_oe", 16'(pic_data_oe), 16'd0);
    chk("abort_init_done", 16'(init_done), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    step(1);
    reset = 0; pic_int = 1;
    quiet(8);
    step(4);
    pic_int = 0;
    drain();
    // start_init during ACK_GAP
    icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'hAA; icw4 = 8'h01; ocw1 = 8'hF0; start_init = 1;
    quiet(1);
    init_seq(8'h13, 8'h20, 8'hAA, 8'h01, 8'hF0);
    step(1);
    start_init = 0;
    drain();
    lows = inta_lows;
    pic_data_in = 8'h66; pic_int = 1;
    quiet(3);
    repeat (S) exp_q.push_back(mk(1, 1, 0, 0, 0, 8'h00, 1));
    repeat (G) exp_q.push_back(mk(1, 1, 1, 0, 0, 8'h00, 1));
    init_seq(8'h13, 8'h20, 8'hAA, 8'h01, 8'hF0);
    quiet(3);
    step(3);
    pic_int = 0;
    step(2);
    start_init = 1;
    step(1);
    start_init = 0;
    drain();
    chk("inta_low_t6", 16'(inta_lows - lows), 16'd2);
    chk("vector_t6", 16'(vector), 16'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
